// File: rtl/n1_pkg.sv
// ============================================================================
// Module   : n1_pkg
// Purpose  : Shared widths and controller state encoding for the n1 neuron.
// Revision : 1.0
// ============================================================================
`default_nettype none

package n1_pkg;

   localparam int N_DEF     = 16;
   localparam int CNT_W_DEF = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_ACC  = 2'd1;
   localparam state_t ST_OUT  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/n1.sv
// ============================================================================
// Module   : n1
// Purpose  : Single multiply/accumulate datapath, res = nbin*sb + nbout mod 2^N.
// Revision : 1.0
// ============================================================================
`default_nettype none

module n1
   import n1_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic [N-1:0] i_nbin,
   input  logic [N-1:0] i_sb,
   input  logic [N-1:0] i_nbout,
   output logic [N-1:0] o_res
);

   // Low N bits of a two's-complement product match the unsigned product's.
   logic [N-1:0] w_prod;

   assign w_prod = i_nbin * i_sb;
   assign o_res  = w_prod + i_nbout;

endmodule

`default_nettype wire

// File: rtl/n1_accum_seq.sv
// ============================================================================
// Module   : n1_accum_seq
// Purpose  : Sequences operand pairs through n1 and hands off the neuron sum.
// Revision : 1.0
// ============================================================================
`default_nettype none

module n1_accum_seq
   import n1_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_len,
   input  logic [N-1:0]     i_bias,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [N-1:0]     i_nbin,
   input  logic [N-1:0]     i_sb,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [N-1:0]     o_out_data,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_count
);

   state_t           state_q, state_d;
   logic [N-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     w_res;

   n1 #(.N(N)) u_n1 (
      .i_nbin  (i_nbin),
      .i_sb    (i_sb),
      .i_nbout (acc_q),
      .o_res   (w_res)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               acc_d   = i_bias;
               cnt_d   = i_len;
               state_d = (i_len == '0) ? ST_OUT : ST_ACC;
            end
         end
         ST_ACC: begin
            if (i_in_valid) begin
               acc_d = w_res;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_OUT;
               end
            end
         end
         ST_OUT: begin
            if (i_out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Accumulator doubles as the result register, so the last sum persists in IDLE.
   assign o_in_ready  = (state_q == ST_ACC);
   assign o_out_valid = (state_q == ST_OUT);
   assign o_out_data  = acc_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_count     = cnt_q;

endmodule

`default_nettype wire
